demux_dispatch: RTL

DEMUX_DISPATCH -- requirements
Module: demux_dispatch

---
 rtl/demux_pkg.sv | 30 +++
 rtl/Demultiplexer_1_to_4_case.sv | 21 ++
 rtl/demux_dispatch.sv | 113 +++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the single-bit demux dispatcher: FSM encoding,
// hold-time bounds and small helpers used by the datapath.
package demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  localparam int HOLD_MIN = 1;
  localparam int HOLD_MAX = 15;
  localparam int HOLD_W   = 4;

  // Keeps an out-of-range hold parameter inside the range the counter can represent.
  function automatic int hold_clamp(input int h);
    if (h < HOLD_MIN) begin
      return HOLD_MIN;
    end else if (h > HOLD_MAX) begin
      return HOLD_MAX;
    end else begin
      return h;
    end
  endfunction

  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/Demultiplexer_1_to_4_case.sv
// Downstream 1:4 demultiplexer: routes din to the Y line selected by A,
// all other lines low.
module Demultiplexer_1_to_4_case (
  input  logic       din,
  input  logic [1:0] A,
  output logic [3:0] Y
);

  // Select decode onto a single output line.
  always_comb begin
    Y = 4'b0000;
    case (A)
      2'b00:   Y = {3'b000, din};
      2'b01:   Y = {2'b00, din, 1'b0};
      2'b10:   Y = {1'b0, din, 2'b00};
      2'b11:   Y = {din, 3'b000};
      default: Y = 4'b0000;
    endcase
  end

endmodule

// File: rtl/demux_dispatch.sv
// Serialises single-bit requests onto a 1:4 demux select/data pair: each bit
// is held for HOLD_CYCLES cycles, followed by one gap cycle with din low.
module demux_dispatch
  import demux_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_data,
  input  logic [1:0] in_addr,
  input  logic       mode,
  output logic       in_ready,
  output logic [1:0] A,
  output logic       din,
  output logic       busy,
  output logic [7:0] sent_cnt
);

  localparam int                HOLD_EFF  = hold_clamp(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_EFF - 1);

  state_t            state_r;
  logic [HOLD_W-1:0] hold_r;
  logic [1:0]        a_r;
  logic [1:0]        rr_r;
  logic              din_r;
  logic              mode_r;
  logic              busy_r;
  logic [7:0]        cnt_r;
  logic [1:0]        chan_s;
  logic              take_s;

  // Channel choice and handshake for the bit on offer this cycle.
  always_comb begin
    chan_s = rr_r;
    take_s = 1'b0;
    if (mode) begin
      chan_s = in_addr;
    end else begin
      chan_s = rr_r;
    end
    if (!rst && (state_r == ST_IDLE) && in_valid) begin
      take_s = 1'b1;
    end else begin
      take_s = 1'b0;
    end
  end

  // Ready is withheld while reset is applied so nothing is offered mid-reset.
  assign in_ready = (state_r == ST_IDLE) && !rst;
  assign A        = a_r;
  assign din      = din_r;
  assign busy     = busy_r;
  assign sent_cnt = cnt_r;

  // Dispatch FSM: capture on transfer, hold the select stable through DRIVE and GAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      hold_r  <= {HOLD_W{1'b0}};
      a_r     <= 2'b00;
      rr_r    <= 2'b00;
      din_r   <= 1'b0;
      mode_r  <= 1'b0;
      busy_r  <= 1'b0;
      cnt_r   <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (take_s) begin
            state_r <= ST_DRIVE;
            a_r     <= chan_s;
            din_r   <= in_data;
            mode_r  <= mode;
            hold_r  <= HOLD_LOAD;
            busy_r  <= 1'b1;
          end else begin
            din_r   <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (hold_r == {HOLD_W{1'b0}}) begin
            state_r <= ST_GAP;
            din_r   <= 1'b0;
          end else begin
            hold_r  <= hold_r - {{(HOLD_W-1){1'b0}}, 1'b1};
          end
        end
        ST_GAP: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          din_r   <= 1'b0;
          cnt_r   <= cnt_r + 8'd1;
          // Addressed dispatches leave the round-robin pointer where it was.
          if (!mode_r) begin
            rr_r <= rr_next(rr_r);
          end else begin
            rr_r <= rr_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          din_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule
